// File: rtl/uni_s2b_decoder_pkg.sv
// uni_s2b_decoder_pkg: shared types and helpers for the unary stochastic-to-binary decoder.
// Revision: 1.0
`default_nettype none

package uni_pkg;

  typedef enum logic [1:0] {
    S2B_IDLE  = 2'd0,
    S2B_ACCUM = 2'd1,
    S2B_DONE  = 2'd2
  } s2b_state_t;

  function automatic int unsigned win_len(input int unsigned bitwidth);
    return 32'd1 << bitwidth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uni_s2b_decoder_if.sv
// uni_s2b_decoder_if: control, stream and result bundle of the stochastic-to-binary decoder.
// Revision: 1.0
`default_nettype none

interface uni_s2b_decoder_if #(
  parameter int BITWIDTH = 8
);

  logic                iClr;
  logic                iStart;
  logic                iBit;
  logic                iBitValid;
  logic                oBusy;
  logic                oValid;
  logic [BITWIDTH-1:0] oResult;
  logic                oSat;

  modport master (
    output iClr, iStart, iBit, iBitValid,
    input  oBusy, oValid, oResult, oSat
  );

  modport slave (
    input  iClr, iStart, iBit, iBitValid,
    output oBusy, oValid, oResult, oSat
  );

endinterface

`default_nettype wire

// File: rtl/uni_s2b_decoder_win_counter.sv
// s2b_win_counter: BITWIDTH+1-bit sample and ones counter pair for one decode window.
// Revision: 1.0
`default_nettype none

module s2b_win_counter
  import uni_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              clr,
  input  logic              en,
  input  logic              stream_bit,
  output logic [BITWIDTH:0] ones,
  output logic              full
);

  localparam logic [BITWIDTH:0] C_LAST = (BITWIDTH+1)'(win_len(BITWIDTH) - 1);

  logic [BITWIDTH:0] r_samples;
  logic [BITWIDTH:0] r_ones;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (clr) begin
      r_samples <= '0;
      r_ones    <= '0;
    end else if (en) begin
      r_samples <= r_samples + 1'b1;
      r_ones    <= r_ones + {{BITWIDTH{1'b0}}, stream_bit};
    end
  end

  assign ones = r_ones;
  // High on the edge that counts the final sample, so the window closes on that same edge.
  assign full = en && (r_samples == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uni_s2b_decoder.sv
// uni_s2b_decoder: counts ones over 2^BITWIDTH valid unary samples and presents the binary value.
// Revision: 1.0
`default_nettype none

module uni_s2b_decoder
  import uni_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  uni_s2b_decoder_if.slave    bus
);

  localparam logic [BITWIDTH:0] C_WIN = (BITWIDTH+1)'(win_len(BITWIDTH));

  s2b_state_t          r_state;
  logic                r_busy;
  logic                r_valid;
  logic [BITWIDTH-1:0] r_result;
  logic                r_sat;

  logic [BITWIDTH:0]   w_ones;
  logic                w_full;
  logic                w_cnt_en;
  logic                w_cnt_clr;

  assign w_cnt_en  = (r_state == S2B_ACCUM) && bus.iBitValid;
  assign w_cnt_clr = bus.iClr || (bus.iStart && (r_state != S2B_ACCUM));

  s2b_win_counter #(
    .BITWIDTH (BITWIDTH)
  ) u_win_counter (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .clr        (w_cnt_clr),
    .en         (w_cnt_en),
    .stream_bit (bus.iBit),
    .ones       (w_ones),
    .full       (w_full)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state  <= S2B_IDLE;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else if (bus.iClr) begin
      r_state  <= S2B_IDLE;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S2B_IDLE: begin
          if (bus.iStart) begin
            r_state <= S2B_ACCUM;
            r_busy  <= 1'b1;
          end
        end
        S2B_ACCUM: begin
          if (w_full) begin
            r_state <= S2B_DONE;
            r_busy  <= 1'b0;
          end
        end
        S2B_DONE: begin
          // A full window of ones does not fit in BITWIDTH bits; clamp and flag it.
          r_valid  <= 1'b1;
          r_result <= w_ones[BITWIDTH] ? '1 : w_ones[BITWIDTH-1:0];
          r_sat    <= (w_ones == C_WIN);
          if (bus.iStart) begin
            r_state <= S2B_ACCUM;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S2B_IDLE;
          end
        end
        default: begin
          r_state <= S2B_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBusy   = r_busy;
  assign bus.oValid  = r_valid;
  assign bus.oResult = r_result;
  assign bus.oSat    = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_uni_s2b_decoder.sv
// tb_uni_s2b_decoder: randomized and directed scoreboard bench for the unary decoder.
// Revision: 1.0
`default_nettype none

module tb_uni_s2b_decoder;

  localparam int BW  = 8;
  localparam int WIN = 1 << BW;

  typedef struct {
    int res;
    int sat;
    int cyc;
  } exp_t;

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;

  uni_s2b_decoder_if #(.BITWIDTH(BW)) bus();

  uni_s2b_decoder #(.BITWIDTH(BW)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_err   = 0;
  exp_t q[$];
  int   pulses[$];
  bit   prev_v  = 1'b0;
  bit   mon_en  = 1'b0;

  // Window-level reference: samples and ones per window, result available one edge after closing.
  bit   m_win  = 1'b0;
  bit   m_fin  = 1'b0;
  int   m_n    = 0;
  int   m_ones = 0;
  int   m_hres = 0;
  int   m_hsat = 0;
  exp_t pend;

  always @(posedge iClk) cyc++;

  task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_err++;
    $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) fail(nm, act, req);
  endtask

  task automatic model_abort();
    if (m_fin) void'(q.pop_back());
    m_win = 0; m_fin = 0; m_n = 0; m_ones = 0; m_hres = 0; m_hsat = 0;
  endtask

  task automatic step(input bit st, input bit cl, input bit b, input bit v);
    bus.iStart = st; bus.iClr = cl; bus.iBit = b; bus.iBitValid = v;
    if (cl) begin
      model_abort();
    end else if (m_fin) begin
      m_fin = 0; m_hres = pend.res; m_hsat = pend.sat;
      m_win = st; m_n = 0; m_ones = 0;
    end else if (!m_win) begin
      if (st) begin m_win = 1; m_n = 0; m_ones = 0; end
    end else if (v) begin
      m_n++;
      m_ones += int'(b);
      if (m_n == WIN) begin
        m_win    = 0;
        m_fin    = 1;
        pend.res = (m_ones >= WIN) ? WIN - 1 : m_ones;
        pend.sat = (m_ones == WIN) ? 1 : 0;
        pend.cyc = cyc + 2;
        q.push_back(pend);
      end
    end
    @(negedge iClk);
    #1;
  endtask

  always @(negedge iClk) begin
    if (iRstN && mon_en) begin
      chk("busy", bus.oBusy, m_win);
      chk("result_hold", bus.oResult, m_hres);
      chk("sat_hold", bus.oSat, m_hsat);
      if (bus.oValid) begin
        if (prev_v) fail("valid_consecutive", 1, 0);
        if (q.size() == 0) begin
          fail("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("valid_result", bus.oResult, e.res);
          chk("valid_sat", bus.oSat, e.sat);
        end
        pulses.push_back(cyc);
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        fail("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      prev_v = bus.oValid;
    end
  end

  function automatic bit gen_bit(input int mode, input int x, input int i);
    int r;
    r = 0;
    for (int k = 0; k < BW; k++) r |= ((i >> k) & 1) << (BW - 1 - k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (i % 2) == 0;
      default: return x > r;
    endcase
  endfunction

  task automatic dir_window(input int mode, input int x, input int res, input int sat, input string nm);
    step(1, 0, 0, 0);
    for (int i = 0; i < WIN; i++) step(0, 0, gen_bit(mode, x, i), 1'b1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk({nm, "_result"}, bus.oResult, res);
    chk({nm, "_sat"}, bus.oSat, sat);
  endtask

  task automatic async_reset_check();
    iRstN = 1'b0;
    #2;
    model_abort();
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_result", bus.oResult, 0);
    chk("rst_sat", bus.oSat, 0);
    @(negedge iClk);
    #1;
    iRstN  = 1'b1;
    prev_v = 1'b0;
  endtask

  initial begin
    int st_cyc;
    bus.iStart = 0; bus.iClr = 0; bus.iBit = 0; bus.iBitValid = 0;
    repeat (3) @(negedge iClk);
    #1;
    async_reset_check();
    mon_en = 1'b1;
    step(0, 0, 1, 1);

    // All ones, with start-to-valid latency.
    pulses.delete();
    st_cyc = cyc + 1;
    dir_window(0, 0, 255, 1, "ones");
    if (pulses.size() > 0) chk("ones_latency", pulses[$] - st_cyc, WIN + 1);
    else fail("ones_latency", 0, WIN + 1);

    dir_window(1, 0, 0, 0, "zeros");
    dir_window(2, 0, 128, 0, "alt");
    dir_window(3, 100, 100, 0, "sobol100");
    dir_window(3, 0, 0, 0, "sobol0");
    dir_window(3, 1, 1, 0, "sobol1");
    dir_window(3, 255, 255, 0, "sobol255");

    // Valid every other cycle.
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * WIN; i++) step(0, 0, 1, (i % 2) == 0);
    step(0, 0, 0, 0);
    chk("gap_result", bus.oResult, 255);
    chk("gap_sat", bus.oSat, 1);

    // Clear at sample 100 aborts the window.
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    chk("clr_busy", bus.oBusy, 0);
    chk("clr_result", bus.oResult, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 1, 1);

    // Start together with clear stays idle.
    step(1, 1, 1, 1);
    step(0, 0, 1, 1);
    chk("start_clr_busy", bus.oBusy, 0);

    // Asynchronous reset mid-window.
    step(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 1);
    async_reset_check();
    step(0, 0, 0, 0);

    // Back-to-back windows with start held high.
    pulses.delete();
    step(1, 0, 0, 0);
    for (int i = 0; i < WIN; i++) step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < WIN; i++) step(i < WIN - 1, 0, gen_bit(2, 0, i), 1'b1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("b2b_pulses", pulses.size(), 2);
    if (pulses.size() == 2) chk("b2b_spacing", pulses[1] - pulses[0], WIN + 1);
    chk("b2b_result", bus.oResult, 128);

    // Randomized windows.
    for (int w = 0; w < 8; w++) begin
      int p;
      p = $urandom_range(0, 100);
      repeat ($urandom_range(0, 3)) step(0, 0, 1'($urandom), 1'($urandom));
      step(1, 0, 0, 0);
      while (m_win) begin
        if (w == 5 && m_n == 37) step(0, 1, 0, 0);
        else step(1'($urandom), 0, ($urandom_range(0, 99) < p), ($urandom_range(0, 3) != 0));
      end
      step(0, 0, 0, 0);
    end

    repeat (4) step(0, 0, 0, 0);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uni_s2b_decoder.md
Name: uni_s2b_decoder

Overview:
- Stochastic-to-binary decoder for unary bitstreams.
- Counts the 1s in a unary bitstream over a fixed window of 2^BITWIDTH valid samples, then presents the binary value.
- Converts the output of a unary multiplier (or any comparator-plus-Sobol-encoded stream) back to binary.
- Used at the end of unary datapaths and in benches as the self-checking sink.

Parameters:
- BITWIDTH, 8, binary result width; window length is 2^BITWIDTH valid samples.

Ports:
- iClk  in  1  clock
- iRstN  in  1  reset
- iClr  in  1  synchronous clear: abort window, clear all state and outputs
- iStart  in  1  begin a new accumulation window
- iBit  in  1  unary stream bit
- iBitValid  in  1  iBit is a sample this cycle
- oBusy  out  1  window in progress
- oValid  out  1  single-cycle pulse: oResult updated
- oResult  out  BITWIDTH  decoded value, held between windows
- oSat  out  1  last window counted 2^BITWIDTH ones; result saturated

Behaviour:
- Reset (iRstN low, asynchronous, active-low; clock iClk): state IDLE, counters 0, oBusy=0, oValid=0, oResult=0, oSat=0.
- State machine states: IDLE, ACCUM, DONE.
- IDLE:
  - iStart=1 -> ACCUM next cycle; sample counter and ones counter cleared to 0.
  - iBit and iBitValid are ignored in IDLE.
- ACCUM:
  - oBusy=1.
  - Each rising edge with iBitValid=1: sample count += 1; ones count += iBit.
  - Both counters are BITWIDTH+1 bits wide.
  - iStart is ignored.
  - When the sample count reaches 2^BITWIDTH, the state goes to DONE. The last sample is counted on that same edge.
  - The first sample counted is the one presented in the first ACCUM cycle, i.e. the cycle after iStart.
- DONE (exactly one cycle):
  - oValid=1 and oBusy=0.
  - oResult = ones count if it is < 2^BITWIDTH, else 2^BITWIDTH-1.
  - oSat = 1 iff ones count == 2^BITWIDTH.
  - oResult and oSat are registered and hold until the next DONE, iClr or reset.
  - If iStart=1 in DONE: go directly to ACCUM with counters cleared (back-to-back windows, no idle cycle). Otherwise -> IDLE.
  - Samples arriving during DONE are not counted.
- Latency: oValid rises on the edge after the edge that captured the 2^BITWIDTH-th valid sample. With continuous iBitValid this is iStart + 2^BITWIDTH + 1 cycles.
- iBitValid gaps stall accumulation; there is no timeout.
- iClr has priority over every transition. It forces IDLE next cycle, clears counters, oResult and oSat, and oValid=0. No oValid is produced for an aborted window.
- Reset mid-window: same effect as iClr, but asynchronous.
- iStart and iClr asserted together: iClr wins, state IDLE.
- oValid is never asserted in two consecutive cycles.

Decomposition:
- Shared package uni_pkg:
  - state enum s2b_state_t {S2B_IDLE, S2B_ACCUM, S2B_DONE}.
  - Function win_len(BITWIDTH) returning 2^BITWIDTH.
- Sub-module s2b_win_counter:
  - Parameterised BITWIDTH+1-bit sample/ones counter pair.
  - Inputs: clr, en, bit. Outputs: ones, full.
  - The top level holds only the FSM and output registers.

Test Plan:
- All-ones stream: iStart pulse, iBit=1, iBitValid=1 for 256 cycles -> single oValid pulse 257 cycles after iStart; oResult=255, oSat=1.
- All-zeros stream over 256 samples -> oResult=0, oSat=0. Alternating 1010... -> oResult=128, oSat=0.
- Sobol-encoded stream: iBit = (100 > sobolseq) with a sobolrng running 256 cycles, aligned to iStart -> oResult=100 exactly. Repeat with 0, 1, 255 -> 0, 1, 255.
- Gapped valid: iBitValid toggling every cycle, iBit=1 -> oValid after 512 sample cycles, oResult=255, oSat=1. oBusy high throughout.
- Abort and priority:
  - iClr at sample 100 of a window -> IDLE next cycle, oResult=0, no oValid.
  - iStart+iClr asserted together -> stays IDLE.
  - iRstN pulse mid-window -> all outputs 0 immediately.
- Back-to-back: iStart held high across two windows (first all-ones, second alternating) -> oValid pulses exactly 257 cycles apart; results 255/oSat=1, then 128/oSat=0. oResult holds between pulses.
